// File: rtl/al_pkg.sv
`default_nettype none
// ============================================================================
// al_pkg : shared constants, FSM encoding and helpers for the free-list arbiter
// Revision: 1.0
// ============================================================================
package al_pkg;

  localparam int PREG_W     = 6;
  localparam int NUM_PREG   = 64;
  localparam int INIT_FIRST = 32;
  localparam int DEPTH      = 16;
  localparam int CNT_W      = $clog2(DEPTH) + 1;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } al_state_e;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/al_free_arb_if.sv
`default_nettype none
// ============================================================================
// al_free_arb_if : scheduler release bus plus free-list write bus
// Revision: 1.0
// ============================================================================
interface al_free_arb_if #(
  parameter int PREG_W = al_pkg::PREG_W,
  parameter int CNT_W  = al_pkg::CNT_W
);

  logic [3:0]        free_vld_from_SCH;
  logic [PREG_W-1:0] free_pr_from_SCH0;
  logic [PREG_W-1:0] free_pr_from_SCH1;
  logic [PREG_W-1:0] free_pr_from_SCH2;
  logic [PREG_W-1:0] free_pr_from_SCH3;
  logic              wr_rdy_from_FL;
  logic [1:0]        wr_vld_to_FL;
  logic [PREG_W-1:0] wr_pr_to_FL0;
  logic [PREG_W-1:0] wr_pr_to_FL1;
  logic              stall_to_SCH;
  logic              init_done_to_AL;
  logic [CNT_W-1:0]  cnt_out;

  modport master (
    output free_vld_from_SCH, free_pr_from_SCH0, free_pr_from_SCH1,
           free_pr_from_SCH2, free_pr_from_SCH3, wr_rdy_from_FL,
    input  wr_vld_to_FL, wr_pr_to_FL0, wr_pr_to_FL1, stall_to_SCH,
           init_done_to_AL, cnt_out
  );

  modport slave (
    input  free_vld_from_SCH, free_pr_from_SCH0, free_pr_from_SCH1,
           free_pr_from_SCH2, free_pr_from_SCH3, wr_rdy_from_FL,
    output wr_vld_to_FL, wr_pr_to_FL0, wr_pr_to_FL1, stall_to_SCH,
           init_done_to_AL, cnt_out
  );

endinterface
`default_nettype wire

// File: rtl/al_free_fifo.sv
`default_nettype none
// ============================================================================
// al_free_fifo : 4-write / 2-read compacting return buffer
// Revision: 1.0
// ============================================================================
module al_free_fifo #(
  parameter int PREG_W = 6,
  parameter int DEPTH  = 16
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   push_en_i,
  input  wire logic [3:0]             push_vld_i,
  input  wire logic [3:0][PREG_W-1:0] push_pr_i,
  input  wire logic                   pop_rdy_i,
  output logic [1:0]                  rd_vld_o,
  output logic [PREG_W-1:0]           rd_pr0_o,
  output logic [PREG_W-1:0]           rd_pr1_o,
  output logic [$clog2(DEPTH):0]      cnt_o
);
  import al_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0][3:0] PRIOR_MASK = {4'b0111, 4'b0011, 4'b0001, 4'b0000};

  logic [PREG_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [3:0]        w_push_vld;
  logic [2:0]        w_push_n;
  logic [1:0]        w_pop_n;
  logic [AW-1:0]     w_head1;
  logic [AW-1:0]     w_wr_idx [4];

  assign w_push_vld = push_en_i ? push_vld_i : 4'b0000;
  assign w_push_n   = popcnt4(w_push_vld);

  // Each valid port lands at tail plus the number of valid lower ports.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      w_wr_idx[p] = tail_q + AW'(popcnt4(w_push_vld & PRIOR_MASK[p]));
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (w_push_vld[p]) mem_q[w_wr_idx[p]] <= push_pr_i[p];
    end
  end

  assign w_head1  = head_q + AW'(1);
  assign rd_vld_o = (cnt_q >= CW'(2)) ? 2'b11 :
                    (cnt_q == CW'(1)) ? 2'b01 : 2'b00;
  assign rd_pr0_o = rd_vld_o[0] ? mem_q[head_q]  : '0;
  assign rd_pr1_o = rd_vld_o[1] ? mem_q[w_head1] : '0;
  assign w_pop_n  = pop_rdy_i ? (2'(rd_vld_o[0]) + 2'(rd_vld_o[1])) : 2'd0;

  assign head_d = head_q + AW'(w_pop_n);
  assign tail_d = tail_q + AW'(w_push_n);
  assign cnt_d  = cnt_q + CW'(w_push_n) - CW'(w_pop_n);
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/al_free_arb.sv
`default_nettype none
// ============================================================================
// al_free_arb : initial free-list fill, then arbitration of released registers
// Revision: 1.0
// ============================================================================
module al_free_arb #(
  parameter int PREG_W     = al_pkg::PREG_W,
  parameter int DEPTH      = al_pkg::DEPTH,
  parameter int INIT_FIRST = al_pkg::INIT_FIRST,
  parameter int NUM_PREG   = al_pkg::NUM_PREG
) (
  input wire logic     clk,
  input wire logic     rst_n,
  al_free_arb_if.slave bus
);
  import al_pkg::*;

  localparam int NUM_PAIRS = (NUM_PREG - INIT_FIRST) / 2;
  localparam int KW        = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int CW        = $clog2(DEPTH) + 1;
  localparam logic [KW-1:0] K_LAST   = KW'(NUM_PAIRS - 1);
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - 4);

  al_state_e         state_q, state_d;
  logic [KW-1:0]     k_q, k_d;

  logic [1:0]        fifo_vld;
  logic [PREG_W-1:0] fifo_pr0, fifo_pr1;
  logic [CW-1:0]     fifo_cnt;

  logic              w_run, w_stall, w_push_en, w_pop_rdy;
  logic [PREG_W-1:0] w_init_pr0;
  logic [1:0]        w_vld;
  logic [PREG_W-1:0] w_pr0, w_pr1;

  assign w_run      = (state_q == RUN);
  assign w_stall    = !w_run || (fifo_cnt > STALL_TH);
  assign w_push_en  = w_run && !w_stall;
  assign w_pop_rdy  = w_run && bus.wr_rdy_from_FL;
  assign w_init_pr0 = PREG_W'(INIT_FIRST) + PREG_W'({k_q, 1'b0});

  al_free_fifo #(
    .PREG_W (PREG_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_en_i  (w_push_en),
    .push_vld_i (bus.free_vld_from_SCH),
    .push_pr_i  ({bus.free_pr_from_SCH3, bus.free_pr_from_SCH2,
                  bus.free_pr_from_SCH1, bus.free_pr_from_SCH0}),
    .pop_rdy_i  (w_pop_rdy),
    .rd_vld_o   (fifo_vld),
    .rd_pr0_o   (fifo_pr0),
    .rd_pr1_o   (fifo_pr1),
    .cnt_o      (fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    w_vld   = 2'b00;
    w_pr0   = '0;
    w_pr1   = '0;
    unique case (state_q)
      INIT: begin
        w_vld = 2'b11;
        w_pr0 = w_init_pr0;
        w_pr1 = w_init_pr0 + PREG_W'(1);
        if (bus.wr_rdy_from_FL) begin
          if (k_q == K_LAST) state_d = RUN;
          else               k_d     = k_q + KW'(1);
        end
      end
      RUN: begin
        w_vld = fifo_vld;
        w_pr0 = fifo_pr0;
        w_pr1 = fifo_pr1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // INIT itself drives 11, so the lanes are forced idle while reset is held.
  assign bus.wr_vld_to_FL    = rst_n ? w_vld : 2'b00;
  assign bus.wr_pr_to_FL0    = rst_n ? w_pr0 : '0;
  assign bus.wr_pr_to_FL1    = rst_n ? w_pr1 : '0;
  assign bus.stall_to_SCH    = w_stall;
  assign bus.init_done_to_AL = w_run;
  assign bus.cnt_out         = fifo_cnt;

endmodule
`default_nettype wire

// File: tb/tb_al_free_arb.sv
`default_nettype none
// Bench for al_free_arb: directed steps plus random traffic checked against a queue model.
module tb_al_free_arb;
  import al_pkg::*;

  localparam int NPAIRS = (NUM_PREG - INIT_FIRST) / 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  al_free_arb_if bus ();

  al_free_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit m_run;
  int m_k;
  int m_total;
  int q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_k   = 0;
    q.delete();
  endtask

  task automatic check_outs(input bit in_reset);
    int n, e_vld, e0, e1, e_st, e_dn, e_cnt;
    n = q.size();
    if (in_reset) begin
      e_vld = 0; e0 = 0; e1 = 0; e_st = 1; e_dn = 0; e_cnt = 0;
    end else if (!m_run) begin
      e_vld = 3; e0 = INIT_FIRST + 2 * m_k; e1 = e0 + 1; e_st = 1; e_dn = 0; e_cnt = 0;
    end else begin
      e_vld = (n >= 2) ? 3 : ((n == 1) ? 1 : 0);
      e0    = (n >= 1) ? q[0] : 0;
      e1    = (n >= 2) ? q[1] : 0;
      e_st  = (n > DEPTH - 4) ? 1 : 0;
      e_dn  = 1;
      e_cnt = n;
    end
    chk("wr_vld",    32'(bus.wr_vld_to_FL),    32'(e_vld));
    chk("wr_pr0",    32'(bus.wr_pr_to_FL0),    32'(e0));
    chk("wr_pr1",    32'(bus.wr_pr_to_FL1),    32'(e1));
    chk("stall",     32'(bus.stall_to_SCH),    32'(e_st));
    chk("init_done", 32'(bus.init_done_to_AL), 32'(e_dn));
    chk("cnt_out",   32'(bus.cnt_out),         32'(e_cnt));
  endtask

  // Drive one cycle of inputs, check current outputs, advance the model, cross the edge.
  task automatic step(input bit rdy, input logic [3:0] vld,
                      input int p0, input int p1, input int p2, input int p3);
    int prs[4];
    int pops;
    bit stall;
    prs[0] = p0; prs[1] = p1; prs[2] = p2; prs[3] = p3;
    bus.wr_rdy_from_FL    = rdy;
    bus.free_vld_from_SCH = vld;
    bus.free_pr_from_SCH0 = PREG_W'(p0);
    bus.free_pr_from_SCH1 = PREG_W'(p1);
    bus.free_pr_from_SCH2 = PREG_W'(p2);
    bus.free_pr_from_SCH3 = PREG_W'(p3);
    #1;
    check_outs(1'b0);
    if (!m_run) begin
      if (rdy) begin
        if (m_k == NPAIRS - 1) m_run = 1'b1;
        else                   m_k++;
      end
    end else begin
      stall = (q.size() > DEPTH - 4);
      pops  = rdy ? ((q.size() >= 2) ? 2 : q.size()) : 0;
      repeat (pops) void'(q.pop_front());
      if (!stall) begin
        for (int i = 0; i < 4; i++) begin
          if (vld[i]) begin
            q.push_back(prs[i]);
            m_total++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_step(input bit rdy);
    step(rdy, 4'($urandom), $urandom_range(0, NUM_PREG - 1), $urandom_range(0, NUM_PREG - 1),
         $urandom_range(0, NUM_PREG - 1), $urandom_range(0, NUM_PREG - 1));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) step(1'b1, 4'b0000, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_total = 0;
    model_reset();
    bus.wr_rdy_from_FL    = 1'b0;
    bus.free_vld_from_SCH = 4'b0000;
    bus.free_pr_from_SCH0 = '0;
    bus.free_pr_from_SCH1 = '0;
    bus.free_pr_from_SCH2 = '0;
    bus.free_pr_from_SCH3 = '0;

    // Reset values while rst_n is held low
    #12;
    check_outs(1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // INIT with wr_rdy 1,0,1 then random; SCH pushes must be ignored
    rnd_step(1'b1);
    chk("r024_pair1", 32'(bus.wr_pr_to_FL0), 32'(INIT_FIRST + 2));
    rnd_step(1'b0);
    chk("r024_hold", 32'(bus.wr_pr_to_FL1), 32'(INIT_FIRST + 3));
    rnd_step(1'b1);
    chk("r024_pair2", 32'(bus.wr_pr_to_FL0), 32'(INIT_FIRST + 4));
    for (int i = 0; i < 200 && !m_run; i++) rnd_step(1'($urandom));
    chk("run_reached", 32'(bus.init_done_to_AL), 32'd1);

    // Empty RUN, ports 1 and 3 valid
    step(1'b0, 4'b1010, 0, 5, 0, 9);
    chk("r025_lane0", 32'(bus.wr_pr_to_FL0), 32'd5);
    chk("r025_lane1", 32'(bus.wr_pr_to_FL1), 32'd9);
    chk("r025_cnt",   32'(bus.cnt_out),      32'd2);

    // Fill to DEPTH, then one dropped push
    drain();
    for (int i = 0; i < 4; i++) step(1'b0, 4'b1111, 4 * i, 4 * i + 1, 4 * i + 2, 4 * i + 3);
    chk("r026_full",  32'(bus.cnt_out),      32'(DEPTH));
    chk("r026_stall", 32'(bus.stall_to_SCH), 32'd1);
    step(1'b0, 4'b1111, 60, 61, 62, 63);
    chk("r026_drop",  32'(bus.cnt_out),      32'(DEPTH));
    drain();

    // Walk head to DEPTH-1 with one entry, then push 4 straddling the wrap
    for (int i = 0; i < 2 * DEPTH && (m_total % DEPTH) != DEPTH - 1; i++) begin
      step(1'b0, 4'b0001, 7, 0, 0, 0);
      step(1'b1, 4'b0000, 0, 0, 0, 0);
    end
    step(1'b0, 4'b0100, 0, 0, 17, 0);
    step(1'b1, 4'b1111, 40, 41, 42, 43);
    chk("r027_cnt",   32'(bus.cnt_out),      32'd4);
    chk("r027_lane0", 32'(bus.wr_pr_to_FL0), 32'd40);
    step(1'b1, 4'b0000, 0, 0, 0, 0);
    chk("r027_lane1", 32'(bus.wr_pr_to_FL1), 32'd43);
    drain();

    // Random traffic: mixed and mostly-ready phases
    for (int i = 0; i < 250; i++) rnd_step(1'($urandom));
    for (int i = 0; i < 250; i++) rnd_step($urandom_range(0, 3) != 0);

    // Occupancy 10 then mid-cycle reset
    drain();
    step(1'b0, 4'b1111, 1, 2, 3, 4);
    step(1'b0, 4'b1111, 5, 6, 7, 8);
    step(1'b0, 4'b0011, 10, 11, 0, 0);
    chk("r028_cnt10", 32'(bus.cnt_out), 32'd10);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs(1'b1);
    @(posedge clk);
    #1;
    check_outs(1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Constant wr_rdy: 16 pairs, init_done on the 17th cycle
    for (int i = 0; i < NPAIRS; i++) begin
      if (i == 0) begin
        #1;
        chk("r028_restart", 32'(bus.wr_pr_to_FL0), 32'(INIT_FIRST));
      end
      rnd_step(1'b1);
    end
    chk("r023_done",  32'(bus.init_done_to_AL), 32'd1);
    chk("r023_stall", 32'(bus.stall_to_SCH),    32'd0);
    for (int i = 0; i < 40; i++) rnd_step(1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/al_free_arb.md
AL_FREE_ARB -- requirements
Module: al_free_arb

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- PREG_W, 6, physical register number width.
- DEPTH, 16, return-buffer entries (power of two).
- INIT_FIRST, 32, first physical register handed to the free list after reset.
- NUM_PREG, 64, total physical registers.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock; all state changes on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- free_vld_from_SCH, in, 4, per-port valid for a released physical register.
- free_pr_from_SCH0..3, in, PREG_W each, released register numbers from scheduler ports 0..3.
- wr_rdy_from_FL, in, 1, the free list accepts writes this cycle.
- wr_vld_to_FL, out, 2, lane valid bits for free-list writes.
- wr_pr_to_FL0/1, out, PREG_W each, register numbers for write lanes 0 and 1.
- stall_to_SCH, out, 1, the scheduler must hold its releases.
- init_done_to_AL, out, 1, initial free-list fill is complete.
- cnt_out, out, log2(DEPTH)+1, buffer occupancy.

Function
REQ-003 The block SHALL have FSM states INIT and RUN; reset SHALL enter INIT.
REQ-004 In INIT, the block SHALL drive INIT_FIRST+2k on lane 0 and INIT_FIRST+2k+1 on lane 1, with wr_vld_to_FL=2'b11. k SHALL advance only on cycles with wr_rdy_from_FL=1.
REQ-005 The INIT->RUN transition SHALL occur on the edge that accepts pair NUM_PREG-2 / NUM_PREG-1; 16 accepted cycles are needed with default parameters.
REQ-006 In INIT, stall_to_SCH SHALL be 1, init_done_to_AL SHALL be 0, and SCH inputs SHALL be ignored.
REQ-007 In RUN, init_done_to_AL SHALL be 1; RUN SHALL be left only by reset.
REQ-008 stall_to_SCH SHALL be 1 in RUN when cnt_out > DEPTH-4, decoded from registered count only, with no input-to-output combinational path.
REQ-009 When stall_to_SCH=0, valid SCH inputs SHALL be written in ascending port order into consecutive buffer slots starting at the tail; invalid ports SHALL leave no gap.
REQ-010 When stall_to_SCH=1, all SCH inputs SHALL be dropped; holding them is the scheduler's duty.
REQ-011 In RUN, lane 0 SHALL present the head entry when cnt>=1 and lane 1 SHALL present head+1 when cnt>=2. wr_vld_to_FL SHALL be 00, 01 or 11; 10 is illegal.
REQ-012 The pop count SHALL be popcount(wr_vld_to_FL) when wr_rdy_from_FL=1, else 0. Output data SHALL hold stable while wr_rdy_from_FL=0.
REQ-013 Occupancy SHALL update as cnt_next = cnt + pushes - pops in the same cycle. An entry pushed at edge N SHALL be visible on a lane no earlier than cycle N+1; there is no bypass.
REQ-014 Head and tail pointers SHALL wrap modulo DEPTH; a 4-entry push straddling the wrap SHALL split across slots DEPTH-1 and 0.
REQ-015 Overflow SHALL be impossible by REQ-008. Underflow SHALL be impossible by REQ-011.
REQ-016 When wr_vld_to_FL=00, wr_pr_to_FL0/1 SHALL be 0.

Reset
REQ-017 With rst_n low, the block SHALL be in state INIT with k=0, cnt_out=0, head=tail=0, stall_to_SCH=1, init_done_to_AL=0, wr_vld_to_FL=00, and wr_pr outputs=0.
REQ-018 The first post-reset cycle SHALL present INIT_FIRST and INIT_FIRST+1 with wr_vld_to_FL=11.
REQ-019 Reset asserted mid-operation SHALL discard all buffered entries and restart the INIT fill.
REQ-020 Buffer data RAM contents need no reset; only pointers, count and FSM SHALL be reset.

Structure
REQ-021 Shared package al_pkg SHALL hold PREG_W, NUM_PREG, INIT_FIRST, DEPTH, and the FSM state enum {INIT, RUN}.
REQ-022 The 4-write/2-read buffer SHALL be one sub-module, al_free_fifo: compaction, pointers, count. The FSM and the INIT counter SHALL stay in the top level.

Verification
REQ-023 Reset, then wr_rdy=1 constantly -> lanes show 32/33, 34/35 ... 62/63 over 16 cycles; init_done rises on cycle 17; stall_to_SCH falls on cycle 17.
REQ-024 INIT with wr_rdy toggling 1,0,1 -> pairs 32/33 then 34/35, with 34/35 held through the 0 cycle; no pair skipped or repeated.
REQ-025 RUN, empty, wr_rdy=0, push vld=4'b1010 with pr1=5, pr3=9 -> next cycle lane0=5, lane1=9, wr_vld=11, cnt=2.
REQ-026 RUN, wr_rdy=0, four pushes of 4 entries -> cnt=12 then 16. stall_to_SCH is 1 from cnt=13 onward; a fifth push is dropped and cnt stays 16.
REQ-027 RUN, cnt=1, head pointer=15, wr_rdy=1, push 4 -> pops 1; cnt=4; entries occupy slots 0..3 and read back in port order.
REQ-028 RUN, cnt=10, rst_n pulsed low mid-cycle -> outputs go to reset values immediately; INIT restarts at 32/33.
